// File: rtl/operand_loader1024.sv
// Operand loader for the 1024x1024 multiplier: packs a word stream into dat1/dat2, times the multiplier latency.
// Optional framing check on s_last/err is enabled with `define OPERAND_LOADER_LAST_CHK_EN.
module operand_loader1024 #(
    parameter int DATA_WIDTH  = 1024,
    parameter int WORD_W      = 64,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] dat1,
    output logic [DATA_WIDTH-1:0] dat2,
    output logic                  busy,
    output logic                  prod_valid,
    input  logic                  prod_ack
`ifdef OPERAND_LOADER_LAST_CHK_EN
    ,
    input  logic                  s_last,
    output logic                  err
`endif
);

    localparam int N    = DATA_WIDTH / WORD_W;
    localparam int WC_W = (N > 1) ? $clog2(N) : 1;
    localparam int LC_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(N - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [WC_W-1:0]       r_word_cnt, w_word_cnt_nxt;
    logic [LC_W-1:0]       r_lat_cnt, w_lat_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_dat1, r_dat2;
    logic                  w_accept;
    logic                  w_word_last;
    logic                  w_abort;

    // New word enters at the MSB end so the first word ends up least significant.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                        input logic [WORD_W-1:0] w);
        shift_in = (cur >> WORD_W) | (DATA_WIDTH'(w) << (DATA_WIDTH - WORD_W));
    endfunction

    assign s_ready     = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign busy        = (r_state == WAIT) || (r_state == DONE);
    assign prod_valid  = (r_state == DONE);
    assign dat1        = r_dat1;
    assign dat2        = r_dat2;
    assign w_accept    = s_valid && s_ready;
    assign w_word_last = (r_word_cnt == WC_LAST);

`ifdef OPERAND_LOADER_LAST_CHK_EN
    logic w_final_word;
    logic w_missing_last;
    logic r_err;

    assign w_final_word   = (r_state == LOAD_B) && w_word_last;
    assign w_abort        = w_accept && s_last && !w_final_word;
    assign w_missing_last = w_accept && !s_last && w_final_word;
    assign err            = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort || w_missing_last;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD_A;
            r_word_cnt <= '0;
            r_lat_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_lat_cnt  <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_lat_cnt_nxt  = r_lat_cnt;
        case (r_state)
            LOAD_A: begin
                if (w_accept) begin
                    if (w_word_last) begin
                        w_state_nxt    = LOAD_B;
                        w_word_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + WC_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (w_accept) begin
                    if (w_word_last) begin
                        w_state_nxt    = WAIT;
                        w_word_cnt_nxt = '0;
                        w_lat_cnt_nxt  = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + WC_W'(1);
                    end
                end
            end
            WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt + LC_W'(1);
                if (r_lat_cnt == LC_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (prod_ack) begin
                    w_state_nxt = LOAD_A;
                end
            end
            default: w_state_nxt = LOAD_A;
        endcase
        // A premature end-of-frame discards the transaction but leaves partial operands in place.
        if (w_abort) begin
            w_state_nxt    = LOAD_A;
            w_word_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat1 <= '0;
            r_dat2 <= '0;
        end else begin
            if (w_accept && (r_state == LOAD_A)) begin
                r_dat1 <= shift_in(r_dat1, s_data);
            end
            if (w_accept && (r_state == LOAD_B)) begin
                r_dat2 <= shift_in(r_dat2, s_data);
            end
        end
    end

endmodule

// File: tb/tb_operand_loader1024.sv
// Scoreboard bench for operand_loader1024: stimulus pushes expected operands/product, a monitor checks on prod_valid.
module tb_operand_loader1024;

    localparam int DW  = 1024;
    localparam int WW  = 64;
    localparam int LAT = 3;
    localparam int N   = DW / WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          prod_ack = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready, busy, prod_valid;
    logic [DW-1:0] dat1, dat2;

`ifdef OPERAND_LOADER_LAST_CHK_EN
    logic err;
    int   err_cnt = 0;
    always @(negedge clk) if (err) err_cnt++;
`endif

    operand_loader1024 #(.DATA_WIDTH(DW), .WORD_W(WW), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dat1(dat1), .dat2(dat2), .busy(busy), .prod_valid(prod_valid), .prod_ack(prod_ack)
`ifdef OPERAND_LOADER_LAST_CHK_EN
        , .s_last(s_last), .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]   d1;
        logic [DW-1:0]   d2;
        logic [2*DW-1:0] prod;
        int              acc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (low 64 bits shown)", name, act[63:0], exp[63:0]);
        end
    endtask

    // Monitor: compare on every rising edge of prod_valid
    logic            pv_q = 1'b0;
    logic [2*DW-1:0] prod_act;
    always @(negedge clk) begin
        if (prod_valid && !pv_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_prod_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                prod_act = {{DW{1'b0}}, dat1} * {{DW{1'b0}}, dat2};
                chk("dat1", dat1, e.d1);
                chk("dat2", dat2, e.d2);
                chk("product", prod_act, e.prod);
                chk("latency", cyc, e.acc + LAT);
            end
        end
        pv_q = prod_valid;
    end

    task automatic send_word(input logic [WW-1:0] w, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        s_last  = last;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1 acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2*DW-1:0] prod,
                            input bit stall, input bit ack_mid, input bit hold_hi, input bit last_ok);
        for (int i = 0; i < 2*N; i++) begin
            if (ack_mid && i == N) prod_ack = 1'b1;
            send_word((i < N) ? a[i*WW +: WW] : b[(i-N)*WW +: WW], (i == 2*N-1) && last_ok);
            if (stall && (i % 5 == 2)) idle(2);
        end
        sb.push_back('{d1: a, d2: b, prod: prod, acc: acc_cyc});
        @(negedge clk);
        chk("busy_after_last", busy, 1);
        chk("s_ready_after_last", s_ready, 0);
        s_last = 1'b0;
        if (hold_hi) begin
            s_valid = 1'b1;
            s_data  = 64'hDEAD_BEEF_CAFE_F00D;
        end else begin
            s_valid = 1'b0;
        end
        if (ack_mid) begin
            @(negedge clk);
            prod_ack = 1'b0;
            chk("ack_in_wait_ignored", prod_valid, 0);
        end
    endtask

    task automatic finish_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        int t;
        t = 0;
        @(negedge clk);
        while (!prod_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("prod_valid_timeout", 0, 1);
        repeat (hold) begin
            @(negedge clk);
            chk("prod_valid_held", prod_valid, 1);
            chk("dat1_stable", dat1, a);
            chk("dat2_stable", dat2, b);
        end
        prod_ack = 1'b1;
        s_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("prod_valid_after_ack", prod_valid, 0);
        chk("s_ready_after_ack", s_ready, 1);
        chk("busy_after_ack", busy, 0);
        prod_ack = 1'b0;
    endtask

    logic [DW-1:0] a, b;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_prod_valid", prod_valid, 0);
        chk("rst_dat1", dat1, 0);
        chk("rst_dat2", dat2, 0);
        rst_n = 1'b1;

        // basic: 1 x 1
        a = 1;
        b = 1;
        send_txn(a, b, 2048'd1, 0, 0, 0, 1);
        finish_txn(a, b, 1);

        // max operands: (2^1024-1)^2 = 2^2048 - 2^1025 + 1
        a = '1;
        b = '1;
        send_txn(a, b, 2048'd1 - (2048'd1 << 1025), 0, 0, 0, 1);
        finish_txn(a, b, 0);

        // stalls in the stream, s_valid held high during WAIT/DONE, ack withheld 10 cycles
        for (int i = 0; i < N; i++) begin
            a[i*WW +: WW] = 64'(i + 1);
            b[i*WW +: WW] = 64'h1000 + 64'(i);
        end
        send_txn(a, b, {{DW{1'b0}}, a} * {{DW{1'b0}}, b}, 1, 0, 1, 1);
        finish_txn(a, b, 10);

        // prod_ack pulsed during LOAD_B and WAIT
        for (int i = 0; i < N; i++) a[i*WW +: WW] = 64'h0123_4567_89AB_CDEF ^ 64'(i);
        b = 3;
        send_txn(a, b, {{DW{1'b0}}, a} * 2048'd3, 0, 1, 0, 1);
        finish_txn(a, b, 2);

        // reset mid-load after 10 words of dat1
        for (int i = 0; i < 10; i++) send_word(64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_dat1", dat1, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 7;
        b = 64'h10;
        send_txn(a, b, 2048'h70, 0, 0, 0, 1);
        finish_txn(a, b, 1);

`ifdef OPERAND_LOADER_LAST_CHK_EN
        begin
            int base;
            base = err_cnt;
            for (int i = 0; i < 5; i++) send_word(64'(i + 9), i == 4);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            @(negedge clk);
            chk("early_last_err", err_cnt, base + 1);
            chk("early_last_s_ready", s_ready, 1);
            a = 5;
            b = 6;
            send_txn(a, b, 2048'd30, 0, 0, 0, 1);
            finish_txn(a, b, 1);
            chk("clean_txn_no_err", err_cnt, base + 1);
            a = 2;
            b = 9;
            send_txn(a, b, 2048'd18, 0, 0, 0, 0);
            finish_txn(a, b, 1);
            chk("missing_last_err", err_cnt, base + 2);
        end
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_loader1024.md
Name: operand_loader1024

Overview:
- Upstream feeder for the 1024x1024 multiplier.
- Assembles both operands from a narrow word stream using a valid/ready handshake, then presents them on dat1/dat2.
- Holds dat1/dat2 stable while the multiplier pipeline settles. The multiplier has no valid signal, so this block times MUL_LATENCY and flags when its product output is valid.
- Releases for the next operand pair once the consumer acknowledges.

Parameters:
- DATA_WIDTH, 1024, operand width. Must be a multiple of WORD_W.
- WORD_W, 64, input stream word width.
- MUL_LATENCY, 3, clock edges from the final operand word being registered to the multiplier product being valid. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_data  input  WORD_W  operand stream word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a word this cycle.
- dat1  output  DATA_WIDTH  operand 1 to the multiplier.
- dat2  output  DATA_WIDTH  operand 2 to the multiplier.
- busy  output  1  operands are frozen (WAIT or DONE).
- prod_valid  output  1  multiplier product port currently valid.
- prod_ack  input  1  consumer has taken the product.

Behaviour:
- N = DATA_WIDTH/WORD_W words per operand; 2N words per transaction. A word is accepted on a rising edge where s_valid && s_ready.
- States: LOAD_A, LOAD_B, WAIT, DONE.
- Reset values (async on rst_n low):
  - state = LOAD_A
  - word_cnt = 0, lat_cnt = 0
  - dat1 = 0, dat2 = 0
  - prod_valid = 0, busy = 0
  - s_ready = 1
- s_ready = 1 in LOAD_A/LOAD_B, 0 in WAIT/DONE. s_data/s_valid are ignored when s_ready = 0.
- busy = 1 in WAIT/DONE; prod_valid = 1 only in DONE. All three are decoded from registered state, with no combinational path from inputs.
- Packing, LSW first:
  - Accepted word shifts into the MSB end: dat1 <= {s_data, dat1[DATA_WIDTH-1:WORD_W]}.
  - After N words, the first word sits at dat1[WORD_W-1:0]. dat2 is packed identically in LOAD_B.
- LOAD_A: each accept increments word_cnt. The accept with word_cnt == N-1 moves to LOAD_B and clears word_cnt.
- LOAD_B: same counting rule. The N-th accept moves to WAIT and clears lat_cnt.
- WAIT:
  - lat_cnt increments every edge. On the edge where lat_cnt == MUL_LATENCY-1, go to DONE.
  - So prod_valid rises exactly MUL_LATENCY edges after the edge that accepted the final word.
- DONE: hold until prod_ack = 1 is sampled, then go to LOAD_A next edge. prod_valid then drops and s_ready rises on the same edge.
- prod_ack outside DONE is ignored.
- dat1/dat2 change only on accepted words. They are never altered in WAIT/DONE and retain old values after DONE until overwritten.
- s_valid gaps (stalls) in LOAD states simply pause counting; there is no timeout.
- rst_n low mid-transaction aborts it: partial operands are cleared to 0 and the block restarts in LOAD_A.

Optional Feature:
- Macro: OPERAND_LOADER_LAST_CHK_EN.
- Defined: adds ports s_last (input, 1) and err (output, 1, reset 0).
  - Early last: s_last on an accepted word other than word 2N. err pulses high one cycle; the transaction is discarded (state LOAD_A, word_cnt 0, dat1/dat2 keep partial contents).
  - Missing last: s_last absent on word 2N. err pulses one cycle, but the transaction proceeds to WAIT normally.
- Undefined: no s_last/err ports; framing is by word count only.

Test Plan (WORD_W=64, DATA_WIDTH=1024, MUL_LATENCY=3, unless noted):
- Basic: words w0=1, w1..w15=0, w16=1, w17..w31=0, s_valid held high.
  - dat1=1, dat2=1; busy rises after w31.
  - prod_valid rises exactly 3 edges after the w31 accept; product=1.
  - prod_ack one cycle later returns to s_ready=1.
- Max operands: all 32 words = 64'hFFFF_FFFF_FFFF_FFFF.
  - dat1=dat2=2^1024-1; product = 2^2048 - 2^1025 + 1 when prod_valid is high.
- Backpressure/stall: s_valid toggled 1,0,0,1 across the stream; also s_valid held high during WAIT/DONE.
  - Only valid&&ready words are counted; no extra words absorbed; dat1/dat2 unchanged during WAIT/DONE.
- Ack handling:
  - prod_ack pulsed during LOAD_B and WAIT: no effect.
  - prod_ack withheld 10 cycles in DONE: prod_valid stays high for all 10 cycles; operands remain stable.
- Reset mid-load: assert rst_n low after 10 words of dat1 (w0 = 64'hA5A5...).
  - Immediately: dat1=0, state LOAD_A, s_ready=1.
  - A fresh 32-word load then completes normally.
- With OPERAND_LOADER_LAST_CHK_EN:
  - s_last on word 5: err pulses once; the next 32-word stream loads correctly.
  - s_last absent on word 32: err pulses; prod_valid still rises after 3 edges.
